memory_write: RTL and testbench
===============================

Name: memory_write

Overview:
Word-addressed write-only RAM port with a small posted-write queue. A producer presents address and data with a `start` strobe. The block buffers each accepted request and commits it to an internal RAM array after a programmable write latency. It sits behind stream-output writers that emit one word per cycle with an incrementing address. A debug read port lets the verification engineer inspect RAM contents.

Parameters:
- SIZE, 1024: number of RAM words.
- ADDRESS_WIDTH, 10: address bus width; must satisfy 2^ADDRESS_WIDTH >= SIZE.
- write_size, 32: word width in bits.
- QUEUE_DEPTH, 4: posted-write queue entries; power of two, >= 2.
- WRITE_CYCLES, 1: cycles a queue-head entry waits before commit; >= 1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- address, input, ADDRESS_WIDTH: word address of the write request.
- data_in, input, write_size: write data.
- start, input, 1: write request strobe, sampled on the rising edge.
- ready, output, 1: the queue can accept a request this cycle.
- idle, output, 1: queue is empty and no commit is pending.
- dbg_address, input, ADDRESS_WIDTH: debug read address.
- dbg_data, output, write_size: combinational read of RAM[dbg_address]; 0 if the address is >= SIZE.

Behaviour:
- Reset (reset=0, asynchronous):
  - queue read/write pointers, entry count and wait counter cleared.
  - ready=1, idle=1.
  - RAM contents are not cleared; they are undefined until written.
- Acceptance:
  - A request is accepted on a rising edge when start=1 and ready=1.
  - address and data_in are captured into the queue tail.
  - start while ready=0 is ignored; the request is not stored. The producer must hold it.
- ready:
  - Combinational: ready = (count < QUEUE_DEPTH).
  - Independent of start, so there is no combinational loop.
- Commit engine:
  - Two states: EMPTY and WAIT.
  - The wait counter loads 1 when an entry becomes head and increments each cycle.
  - On the edge where counter == WRITE_CYCLES, RAM[head.address] <= head.data, the head is popped, and the counter reloads for the next entry if one exists.
  - With WRITE_CYCLES=1, a request accepted at edge k is committed at edge k+1. Sustained throughput is then one word per cycle, and ready never drops under continuous start.
  - With WRITE_CYCLES=N, sustained throughput is one commit per N cycles.
- Simultaneous push and pop in one edge: count unchanged; both operations take effect.
- Full queue: ready=0. A pop on that edge makes ready=1 for the following cycle.
- Out-of-range address (>= SIZE): the entry is accepted and popped normally, but no RAM word changes.
- Same address written repeatedly: commits occur in acceptance order; the last accepted value wins.
- Pointer wrap-around: pointers wrap modulo QUEUE_DEPTH; count is tracked separately and is 0..QUEUE_DEPTH.
- Reset mid-operation: pending queue entries are discarded without committing. Already-committed RAM words keep their values.
- idle = (count == 0). It goes high on the edge that pops the last entry.
- dbg_data reflects a commit immediately after the committing edge. There is no read-during-write bypass of queued entries.

Test Plan:
- Reset then single write: assert reset=0, release; check ready=1, idle=1. Apply start=1 with address=5, data_in=0xDEADBEEF for 1 cycle. Expect dbg_data at address 5 = 0xDEADBEEF one edge later, and idle=1 afterwards.
- Streaming write (WRITE_CYCLES=1): start held for 16 cycles, address 0..15, data 0x1000+i. Expect ready=1 throughout and RAM[i] = 0x1000+i for all i.
- Backpressure (WRITE_CYCLES=3, QUEUE_DEPTH=4): continuous start with incrementing data. Expect ready=0 once 4 entries are pending. Requests while ready=0 are not stored. Data that was accepted lands at its own address, with no gaps or duplicates.
- Overwrite ordering: write 0x11 then 0x22 to address 7 on consecutive cycles. Expect final RAM[7] = 0x22.
- Out-of-range: SIZE=1000, write address 1010 with data 0xFF. Expect the entry popped (idle returns to 1) and dbg_data at address 1010 = 0. Address 999 written with 0xAB reads back 0xAB.
- Reset mid-operation (WRITE_CYCLES=4): queue 3 writes, assert reset before the first commit. Expect count cleared, ready=1, idle=1, and the target words unchanged from their prior values.

Source files
------------

// File: rtl/memory_write_if.sv
// Write-request / debug-read bundle between a word producer and memory_write.
// Latency: none; this is wiring only.
// Backpressure: ready qualifies start; the producer holds its request while ready is low.
interface memory_write_if #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int write_size    = 32
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic [write_size-1:0]    data_in;
    logic                     start;
    logic                     ready;
    logic                     idle;
    logic [ADDRESS_WIDTH-1:0] dbg_address;
    logic [write_size-1:0]    dbg_data;

    // Producer side: drives requests and the debug address.
    modport master (
        output address, data_in, start, dbg_address,
        input  ready, idle, dbg_data
    );

    // Memory side: consumes requests and answers debug reads.
    modport slave (
        input  address, data_in, start, dbg_address,
        output ready, idle, dbg_data
    );
endinterface

// File: rtl/memory_write.sv
// Posted-write RAM port: queues address/data requests and commits them to a word RAM.
// Latency: a request accepted at edge k commits at edge k+WRITE_CYCLES when it is queue head.
// Backpressure: ready drops while QUEUE_DEPTH entries are pending; start is ignored then.
module memory_write #(
    parameter int SIZE          = 1024,
    parameter int ADDRESS_WIDTH = 10,
    parameter int write_size    = 32,
    parameter int QUEUE_DEPTH   = 4,
    parameter int WRITE_CYCLES  = 1
) (
    input  logic          clk,
    input  logic          reset,
    memory_write_if.slave bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(WRITE_CYCLES + 1);
    localparam int IDX_W = (SIZE < 2) ? 1 : $clog2(SIZE);

    localparam logic [PTR_W:0]         QD_W   = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] SIZE_W = (ADDRESS_WIDTH + 1)'(SIZE);
    localparam logic [CNT_W-1:0]       WC_W   = CNT_W'(WRITE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);

    // EMPTY: nothing queued. WAIT: the head entry is ageing toward its commit edge.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    // Commit engine and queue bookkeeping.
    state_t             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    // Queue payload and RAM array carry no reset; only the pointers decide validity.
    logic [ADDRESS_WIDTH-1:0] r_q_addr [QUEUE_DEPTH];
    logic [write_size-1:0]    r_q_data [QUEUE_DEPTH];
    logic [write_size-1:0]    r_ram    [SIZE];

    logic                     w_ready;
    logic                     w_push;
    logic                     w_pop;
    logic [PTR_W:0]           w_count_next;
    logic [ADDRESS_WIDTH-1:0] w_head_addr;
    logic [write_size-1:0]    w_head_data;
    logic                     w_head_in_range;
    logic [IDX_W-1:0]         w_head_idx;
    logic                     w_dbg_in_range;
    logic [IDX_W-1:0]         w_dbg_idx;

    // ready depends only on the registered count, so start never loops back into it.
    assign w_ready = (r_count < QD_W);
    assign w_push  = bus.start && w_ready;
    assign w_pop   = (r_state == ST_WAIT) && (r_wait_cnt == WC_W);

    assign bus.ready = w_ready;
    assign bus.idle  = (r_count == '0);

    // Head of queue; out-of-range heads are popped without touching the RAM.
    assign w_head_addr     = r_q_addr[r_rd_ptr];
    assign w_head_data     = r_q_data[r_rd_ptr];
    assign w_head_in_range = ({1'b0, w_head_addr} < SIZE_W);
    assign w_head_idx      = w_head_addr[IDX_W-1:0];

    // Debug read sees only committed words; queued entries are not bypassed.
    assign w_dbg_in_range = ({1'b0, bus.dbg_address} < SIZE_W);
    assign w_dbg_idx      = bus.dbg_address[IDX_W-1:0];
    assign bus.dbg_data   = w_dbg_in_range ? r_ram[w_dbg_idx] : '0;

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Pointers, count and the commit FSM; reset drops pending entries uncommitted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_wait_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case (r_state)
                ST_EMPTY: begin
                    // A push into an empty queue makes that entry head right away.
                    if (w_push) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (w_pop) begin
                        // Next entry (already queued or pushed this edge) starts ageing.
                        if (w_count_next != '0) begin
                            r_wait_cnt <= CNT_ONE;
                        end else begin
                            r_state    <= ST_EMPTY;
                            r_wait_cnt <= '0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Capture accepted requests at the queue tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= bus.address;
            r_q_data[r_wr_ptr] <= bus.data_in;
        end
    end

    // Commit the head entry into the RAM when its wait expires.
    always_ff @(posedge clk) begin
        if (w_pop && w_head_in_range) begin
            r_ram[w_head_idx] <= w_head_data;
        end
    end
endmodule

// File: tb/tb_memory_write.sv
// Self-checking bench for memory_write using three parameterisations of the block.
// Accepted requests go into a scoreboard queue; after the DUT drains, entries are
// popped and compared against RAM contents read through the debug port.
module tb_memory_write;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    memory_write_if #(.ADDRESS_WIDTH(AW), .write_size(DW)) if_a ();
    memory_write_if #(.ADDRESS_WIDTH(AW), .write_size(DW)) if_b ();
    memory_write_if #(.ADDRESS_WIDTH(AW), .write_size(DW)) if_c ();

    // A: single-cycle commit, reduced SIZE for out-of-range checks.
    memory_write #(.SIZE(1000), .ADDRESS_WIDTH(AW), .write_size(DW),
                   .QUEUE_DEPTH(4), .WRITE_CYCLES(1))
        u_dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
    // B: slow commit so the queue fills.
    memory_write #(.SIZE(1024), .ADDRESS_WIDTH(AW), .write_size(DW),
                   .QUEUE_DEPTH(4), .WRITE_CYCLES(3))
        u_dut_b (.clk(clk), .reset(rst_b), .bus(if_b));
    // C: long wait so a reset can land before the first commit.
    memory_write #(.SIZE(1024), .ADDRESS_WIDTH(AW), .write_size(DW),
                   .QUEUE_DEPTH(4), .WRITE_CYCLES(4))
        u_dut_c (.clk(clk), .reset(rst_c), .bus(if_c));

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    localparam logic [AW-1:0] BOGUS_A = 10'd500;
    localparam logic [DW-1:0] BOGUS_D = 32'hBAD0_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int which);
        case (which)
            0:       return if_a.ready;
            1:       return if_b.ready;
            default: return if_c.ready;
        endcase
    endfunction

    function automatic logic get_idle(input int which);
        case (which)
            0:       return if_a.idle;
            1:       return if_b.idle;
            default: return if_c.idle;
        endcase
    endfunction

    function automatic int get_size(input int which);
        return (which == 0) ? 1000 : 1024;
    endfunction

    task automatic set_req(input int which, input logic st, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        case (which)
            0: begin if_a.start = st; if_a.address = a; if_a.data_in = d; end
            1: begin if_b.start = st; if_b.address = a; if_b.data_in = d; end
            default: begin if_c.start = st; if_c.address = a; if_c.data_in = d; end
        endcase
    endtask

    task automatic dbg_read(input int which, input logic [AW-1:0] a, output logic [DW-1:0] d);
        case (which)
            0:       if_a.dbg_address = a;
            1:       if_b.dbg_address = a;
            default: if_c.dbg_address = a;
        endcase
        #1;
        case (which)
            0:       d = if_a.dbg_data;
            1:       d = if_b.dbg_data;
            default: d = if_c.dbg_data;
        endcase
    endtask

    // Producer: holds each request until accepted. With inject set, cycles where
    // ready is low carry a bogus request instead, which must never be stored.
    task automatic stream(input int which, input int n, input logic [AW-1:0] abase,
                          input int astep, input logic [DW-1:0] dbase, input int dstep,
                          input bit inject, output int n_stall, output int acc_at_full);
        int            i;
        int            cyc;
        logic          r;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        i           = 0;
        cyc         = 0;
        n_stall     = 0;
        acc_at_full = -1;
        while (i < n && cyc < 16 * n + 32) begin
            @(negedge clk);
            r = get_ready(which);
            if (!r && acc_at_full < 0) acc_at_full = i;
            a = abase + AW'(i * astep);
            d = dbase + DW'(i * dstep);
            if (r || !inject) set_req(which, 1'b1, a, d);
            else              set_req(which, 1'b1, BOGUS_A, BOGUS_D | DW'(cyc));
            @(posedge clk);
            if (r) begin
                sb_q.push_back('{addr: a, data: d});
                i++;
            end else begin
                n_stall++;
            end
            cyc++;
        end
        @(negedge clk);
        set_req(which, 1'b0, '0, '0);
        check("stream_accepted", i, n);
    endtask

    task automatic wait_idle(input int which, input string tag);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (get_idle(which)) break;
        end
        check(tag, {31'd0, get_idle(which)}, 32'd1);
    endtask

    // Pop every accepted write in order; the last value per address must be in RAM,
    // and addresses beyond SIZE must read back as zero.
    task automatic sb_check(input int which, input string tag);
        logic [DW-1:0] model [int];
        logic [DW-1:0] got;
        logic [DW-1:0] exp;
        wr_t           e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            model[int'(e.addr)] = e.data;
        end
        foreach (model[k]) begin
            exp = (k < get_size(which)) ? model[k] : '0;
            dbg_read(which, AW'(k), got);
            check(tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            stall;
        int            full_at;
        logic [DW-1:0] rd;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        set_req(2, 1'b0, '0, '0);
        if_a.dbg_address = '0; if_b.dbg_address = '0; if_c.dbg_address = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, if_a.ready}, 32'd1);
        check("rst_idle",  {31'd0, if_a.idle},  32'd1);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, if_a.ready}, 32'd1);
        check("post_rst_idle",  {31'd0, if_a.idle},  32'd1);

        // Single write: committed exactly one edge after acceptance.
        stream(0, 1, 10'd5, 0, 32'hDEAD_BEEF, 0, 1'b0, stall, full_at);
        check("single_busy", {31'd0, if_a.idle}, 32'd0);
        @(negedge clk);
        dbg_read(0, 10'd5, rd);
        check("single_latency", rd, 32'hDEAD_BEEF);
        check("single_idle", {31'd0, if_a.idle}, 32'd1);
        sb_check(0, "single_sb");

        // Streaming at one word per cycle: ready never drops.
        stream(0, 16, 10'd0, 1, 32'h0000_1000, 1, 1'b0, stall, full_at);
        check("stream_stalls", stall, 0);
        wait_idle(0, "stream_idle");
        sb_check(0, "stream_sb");

        // Back-to-back writes to one address: last one wins.
        stream(0, 2, 10'd7, 0, 32'h11, 32'h11, 1'b0, stall, full_at);
        wait_idle(0, "ovw_idle");
        sb_check(0, "ovw_sb");

        // Out-of-range entry is popped without effect; top valid word still writes.
        stream(0, 1, 10'd1010, 0, 32'hFF, 0, 1'b0, stall, full_at);
        wait_idle(0, "oor_idle");
        stream(0, 1, 10'd999, 0, 32'hAB, 0, 1'b0, stall, full_at);
        wait_idle(0, "oor_top_idle");
        sb_check(0, "oor_sb");

        // Backpressure with WRITE_CYCLES=3: ready first drops after five acceptances.
        stream(1, 1, BOGUS_A, 0, 32'h5555, 0, 1'b0, stall, full_at);
        wait_idle(1, "bp_pre_idle");
        sb_check(1, "bp_pre_sb");
        stream(1, 12, 10'd100, 1, 32'h0000_2000, 1, 1'b1, stall, full_at);
        check("bp_full_point", full_at, 5);
        check("bp_stalled", {31'd0, stall > 0}, 32'd1);
        wait_idle(1, "bp_idle");
        sb_check(1, "bp_sb");
        dbg_read(1, BOGUS_A, rd);
        check("bp_dropped", rd, 32'h5555);

        // Reset before the first commit discards the pending entries.
        stream(2, 3, 10'd20, 1, 32'hC0, 1, 1'b0, stall, full_at);
        wait_idle(2, "mid_pre_idle");
        sb_check(2, "mid_pre_sb");
        stream(2, 3, 10'd20, 1, 32'hEE0, 1, 1'b0, stall, full_at);
        check("mid_pending", {31'd0, if_c.idle}, 32'd0);
        rst_c = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_ready", {31'd0, if_c.ready}, 32'd1);
        check("mid_rst_idle",  {31'd0, if_c.idle},  32'd1);
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_after_idle", {31'd0, if_c.idle}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            dbg_read(2, 10'(20 + i), rd);
            check("mid_ram_kept", rd, 32'hC0 + 32'(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
